// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: synchronised line edges, mask, lowest-index priority, REQ/SERVICE handshake.
// Defining IRQ_TIMEOUT_EN adds an acknowledge timeout that drops the request and sets a sticky irq_timeout flag.
module irq_ctrl #(
   parameter int NLINES  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NLINES-1:0]         irq_lines,
   input  logic                      mask_we,
   input  logic [NLINES-1:0]         mask_wdata,
   input  logic                      ExtIAck,
   input  logic                      ERet,
   output logic                      ExtIRQ,
   output logic [$clog2(NLINES)-1:0] irq_id,
   output logic [NLINES-1:0]         irq_pending,
   output logic                      irq_busy,
   output logic                      irq_timeout
);
   localparam int IDW = $clog2(NLINES);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t            r_state;
   logic [NLINES-1:0] r_sync1, r_sync2, r_hist;
   logic [NLINES-1:0] r_pend, r_mask;
   logic [IDW-1:0]    r_id;
   logic              r_extirq, r_busy;
   logic [NLINES-1:0] w_edge, w_elig, w_clr;
   logic              w_take;

   generate
      if (NLINES < 2 || NLINES > 16 || (NLINES & (NLINES - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
         $error("irq_ctrl: NLINES must be a power of two in 2..16 and TIMEOUT must be >= 1");
      end
   endgenerate

   function automatic logic [IDW-1:0] f_lowest(input logic [NLINES-1:0] v);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = NLINES - 1; i >= 0; i--) begin
         if (v[i]) idx = IDW'(i);
      end
      return idx;
   endfunction

`ifdef IRQ_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] r_cnt;
   logic          r_timeout;
   assign irq_timeout = r_timeout;
`else
   assign irq_timeout = 1'b0;
`endif

   // Two-flop synchroniser plus history flop; an edge is a fresh 1 in the synchronised stream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_hist  <= '0;
      end else begin
         r_sync1 <= irq_lines;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_hist;
   assign w_elig = r_pend & r_mask;
   assign w_take = (r_state == S_REQ) && ExtIAck;
   assign w_clr  = w_take ? (NLINES'(1) << r_id) : '0;

   // A new edge on the line being acknowledged wins over its clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_mask <= '1;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_edge;
         if (mask_we) r_mask <= mask_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_extirq <= 1'b0;
         r_busy   <= 1'b0;
         r_id     <= '0;
`ifdef IRQ_TIMEOUT_EN
         r_cnt     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_elig) begin
                  r_state  <= S_REQ;
                  r_extirq <= 1'b1;
                  r_id     <= f_lowest(w_elig);
`ifdef IRQ_TIMEOUT_EN
                  r_cnt    <= '0;
`endif
               end
            end
            S_REQ: begin
               // Request and id stay frozen here regardless of mask/pending activity.
               if (ExtIAck) begin
                  r_state  <= S_SERVICE;
                  r_extirq <= 1'b0;
                  r_busy   <= 1'b1;
               end
`ifdef IRQ_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_state   <= S_IDLE;
                  r_extirq  <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
`endif
            end
            S_SERVICE: begin
               if (ERet) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_extirq <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign ExtIRQ      = r_extirq;
   assign irq_busy    = r_busy;
   assign irq_id      = r_id;
   assign irq_pending = r_pend;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NLINES, default 8, number of external interrupt lines; SHALL be a power of two, range 2 to 16.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for acknowledge; used only when IRQ_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 irq_lines  in  NLINES  raw asynchronous external interrupt sources; a rising edge requests an interrupt.
REQ-006 mask_we  in  1  write strobe for the mask register.
REQ-007 mask_wdata  in  NLINES  new mask value; bit=1 enables the line.
REQ-008 ExtIAck  in  1  acknowledge from controller; means the external interrupt was taken.
REQ-009 ERet  in  1  return-from-exception from controller; ends service.
REQ-010 ExtIRQ  out  1  interrupt request to controller.
REQ-011 irq_id  out  $clog2(NLINES)  index of the line being requested or serviced.
REQ-012 irq_pending  out  NLINES  current pending register.
REQ-013 irq_busy  out  1  high in SERVICE state.
REQ-014 irq_timeout  out  1  sticky flag: an acknowledge timed out.

Function
REQ-015 Each line SHALL pass through a 2-flop synchronizer followed by a 1-flop history stage; an edge SHALL be detected when sync=1 and history=0.
REQ-016 A detected edge SHALL set its pending bit on the next clock edge, whatever the mask; a level held high SHALL NOT set the bit again.
REQ-017 Latency: input rising before clock edge N, meeting setup, SHALL give pending set after edge N+2 and ExtIRQ=1 after edge N+3.
REQ-018 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-019 IDLE->REQ when (pending & mask)!=0; irq_id SHALL latch the lowest set index on that edge.
REQ-020 REQ: ExtIRQ=1; irq_id and the request SHALL hold stable until ExtIAck, even if mask or pending change.
REQ-021 REQ with ExtIAck=1 SHALL clear pending[irq_id] and go to SERVICE; ExtIRQ SHALL be 0 from the next cycle.
REQ-022 SERVICE: irq_busy=1 and ExtIRQ=0; no nesting; a new edge SHALL only set pending; ERet=1 SHALL return the FSM to IDLE.
REQ-023 ExtIAck outside REQ and ERet outside SERVICE SHALL be ignored.
REQ-024 If a new edge on line irq_id coincides with its clear, the set SHALL win and the bit stays pending.
REQ-025 On mask_we=1 the mask SHALL load mask_wdata on the next edge; the new value SHALL affect the IDLE decision from the following cycle.
REQ-026 If ERet coincides with pending & mask != 0, the FSM SHALL pass through IDLE for one cycle before REQ.

Reset
REQ-027 On reset=0 the block SHALL immediately set:
- state=IDLE
- ExtIRQ=0, irq_id=0, irq_busy=0, irq_timeout=0
- pending=0, all synchronizer and history flops=0
- mask=all ones
REQ-028 Reset asserted mid-REQ or mid-SERVICE SHALL drop any request without an acknowledge.
REQ-029 After deassertion, a line already high SHALL register one edge.

Configuration
REQ-030 Macro IRQ_TIMEOUT_EN defined: a counter SHALL clear on entering REQ and increment each REQ cycle.
- When it reaches TIMEOUT without ExtIAck, the FSM SHALL go to IDLE, set irq_timeout, and leave pending set.
- irq_timeout SHALL clear only on reset.
REQ-031 Macro IRQ_TIMEOUT_EN undefined: no counter SHALL exist, REQ SHALL wait for ExtIAck indefinitely, and irq_timeout SHALL be tied to 0.

Verification
REQ-032 Pulse irq_lines[3] at edge 10, no ack -> pending=0x08 after edge 12, ExtIRQ=1 and irq_id=3 after edge 13.
REQ-033 Lines 5 and 2 rise together, ack each, then ERet -> first irq_id=2 is serviced, pending=0x20 remains, then irq_id=5 is requested after IDLE.
REQ-034 mask=0xF7, pulse line 3 -> ExtIRQ stays 0 and pending=0x08; write mask=0xFF -> ExtIRQ=1 two cycles after mask_we.
REQ-035 In SERVICE, pulse line 1, then ERet -> ExtIRQ=0 until ERet; after ERet, IDLE for one cycle, then REQ with irq_id=1.
REQ-036 In REQ, assert reset=0 -> ExtIRQ=0, pending=0 and mask=0xFF immediately, with no clock needed.
REQ-037 With IRQ_TIMEOUT_EN and TIMEOUT=4, withhold ExtIAck -> after 4 REQ cycles ExtIRQ=0, irq_timeout=1, pending bit still set.
